arbitro_somador: RTL and testbench
==================================

// Module: arbitro_somador
// PURPOSE
//  Round-robin arbiter/sequencer sharing one clocked adder (WIDTH-bit, registered result)
//  among NUM_REQ requesters. Holds the granted requester's operands on the adder,
//  waits LATENCY cycles, returns the sum with a one-cycle done pulse.
//  Sits between processor units needing additions (PC increment, address calc, ALU)
//  and the single shared adder instance.
// PARAMETERS
//  WIDTH    32  operand/result width
//  NUM_REQ  4   number of requesters (2..8)
//  LATENCY  1   adder cycles from stable operands to valid soma_res (>=1)
// PORTS
//  clock      in   1              system clock, rising edge
//  reset      in   1              asynchronous, active-high
//  req        in   NUM_REQ        req[i]: requester i wants an addition
//  entrada1   in   NUM_REQ*WIDTH  operand A, slice i = requester i
//  entrada2   in   NUM_REQ*WIDTH  operand B, slice i = requester i
//  grant      out  NUM_REQ        one-hot, requester currently owning the adder
//  done       out  NUM_REQ        one-hot, one-cycle pulse: resultado valid for that requester
//  resultado  out  WIDTH          registered sum of last completed operation
//  soma_a     out  WIDTH          operand A driven to shared adder
//  soma_b     out  WIDTH          operand B driven to shared adder
//  soma_res   in   WIDTH          adder result
// BEHAVIOUR
//  - Reset (async, immediate): state=OCIOSO, grant=0, done=0, resultado=0, soma_a=0,
//    soma_b=0, counter=0, priority pointer ptr=0. Operation in flight is dropped, no done.
//  - FSM OCIOSO -> OCUPADO -> RESPOSTA -> OCIOSO.
//  - OCIOSO: on edge with req!=0, pick first asserted req scanning ptr, ptr+1, ... mod NUM_REQ.
//    The same edge registers grant=onehot(g), soma_a=entrada1[g], soma_b=entrada2[g], and
//    counter=LATENCY-1. Next state OCUPADO. With req==0, no change.
//  - OCUPADO: lasts exactly LATENCY cycles. Operands frozen, req/entrada ignored. Counter
//    decrements. On the edge with counter==0: resultado<=soma_res, done<=onehot(g),
//    grant<=0, ptr<=(g+1) mod NUM_REQ, next RESPOSTA.
//  - RESPOSTA: one cycle, done high. Requests are ignored on the exiting edge, so the
//    served requester may drop req on that edge without being re-granted. done<=0, next OCIOSO.
//  - Timing: req seen at edge k -> grant high after k -> done high after edge k+LATENCY
//    for 1 cycle. Peak throughput: 1 op per LATENCY+2 cycles.
//  - Requester contract: hold req and operands until done. Operands are captured at grant,
//    so changing them later has no effect. Dropping req after grant does not abort; done
//    still pulses.
//  - Arithmetic: resultado = (A+B) mod 2^WIDTH as delivered by the adder; no carry/overflow out.
//  - Simultaneous requests: round-robin; the winner becomes lowest priority next.
//    No starvation: any held req is served within NUM_REQ operations.
//  - grant and done each have at most one bit set (one-hot or zero), always.
// STRUCTURE
//  - arbitro_defs.vh: state encodings ST_OCIOSO=2'd0, ST_OCUPADO=2'd1, ST_RESPOSTA=2'd2;
//    default WIDTH/NUM_REQ/LATENCY constants.
//  - Sub-module prioridade_rr: combinational round-robin picker (req, ptr -> one-hot winner,
//    index, any). FSM, counter and operand muxing stay in arbitro_somador.
//  - Bench instantiates arbitro_somador plus the real clocked adder wired via soma_*.
// TESTING
//  1 Reset: assert reset during OCUPADO with grant=0010 -> grant, done, resultado, soma_a/b
//    = 0 before next edge; no done follows; next single req[1] is served normally.
//  2 Single op: req=0001, A0=1, B0=3, LATENCY=1 -> soma_a=1, soma_b=3, grant=0001 one edge
//    later; done=0001, resultado=4 two edges after sampling; grant=0.
//  3 Contention: req=1111 held (each drops on its done), Ai=i, Bi=10 -> done order 0,1,2,3
//    with resultado 10,11,12,13; 4 ops in 12 cycles.
//  4 Wrap-around: A=32'hFFFF_FFFF, B=1 -> resultado=0; A=32'h8000_0000, B=32'h8000_0000 -> 0.
//  5 Fairness: req[0] and req[2] re-asserted immediately after each done -> grants alternate
//    0,2,0,2; neither is granted twice in a row while the other waits.
//  6 Early drop: req[3] deasserted during OCUPADO, A3 changed -> done[3] still pulses with
//    the originally captured sum; LATENCY=3 run verifies done 4 edges after sampling.

Source files
------------

// File: rtl/arbitro_somador_pkg.sv
// Shared definitions for the round-robin adder arbiter.
// FSM state encoding, default parameters and a pointer helper.
package arbitro_somador_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_OCIOSO   = 2'd0,
    ST_OCUPADO  = 2'd1,
    ST_RESPOSTA = 2'd2
  } estado_t;

  function automatic int proximo(input int i, input int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/prioridade_rr.sv
// Combinational round-robin picker: first asserted request
// scanning from ptr upward, wrapping modulo NUM_REQ.
module prioridade_rr #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         winner,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  int pos;

  always_comb begin
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      pos = (int'(ptr) + off) % NUM_REQ;
      if (!any && req[pos]) begin
        any         = 1'b1;
        idx         = IW'(pos);
        winner[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_somador.sv
// Round-robin sequencer sharing one clocked adder among
// NUM_REQ requesters; done pulses one cycle with the sum.
module arbitro_somador
  import arbitro_somador_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] entrada1,
  input  logic [NUM_REQ*WIDTH-1:0] entrada2,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       done,
  output logic [WIDTH-1:0]         resultado,
  output logic [WIDTH-1:0]         soma_a,
  output logic [WIDTH-1:0]         soma_b,
  input  logic [WIDTH-1:0]         soma_res
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  estado_t          estado;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    cnt;

  logic [NUM_REQ-1:0] win;
  logic [IW-1:0]      win_idx;
  logic               win_any;

  prioridade_rr #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req    (req),
    .ptr    (ptr),
    .winner (win),
    .idx    (win_idx),
    .any    (win_any)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= ST_OCIOSO;
      grant     <= '0;
      done      <= '0;
      resultado <= '0;
      soma_a    <= '0;
      soma_b    <= '0;
      cnt       <= '0;
      ptr       <= '0;
      idx_q     <= '0;
    end else begin
      unique case (estado)
        ST_OCIOSO: begin
          if (win_any) begin
            grant  <= win;
            idx_q  <= win_idx;
            soma_a <= entrada1[win_idx*WIDTH +: WIDTH];
            soma_b <= entrada2[win_idx*WIDTH +: WIDTH];
            cnt    <= CW'(LATENCY - 1);
            estado <= ST_OCUPADO;
          end
        end
        ST_OCUPADO: begin
          // operands stay frozen while the adder settles
          if (cnt == '0) begin
            resultado <= soma_res;
            done      <= grant;
            grant     <= '0;
            ptr       <= IW'(proximo(int'(idx_q), NUM_REQ));
            estado    <= ST_RESPOSTA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESPOSTA: begin
          done   <= '0;
          estado <= ST_OCIOSO;
        end
        default: estado <= ST_OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_somador.sv
// Self-checking bench: table vectors, hand sequences and a
// randomized run against a round-robin model; two latencies.
module tb_arbitro_somador;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]        req1;
  logic [3:0][31:0]  e1, e2;
  logic [3:0]        grant1, done1;
  logic [31:0]       res1, sa1, sb1, sres1;

  logic [3:0]        req3;
  logic [3:0][31:0]  f1, f2;
  logic [3:0]        grant3, done3;
  logic [31:0]       res3, sa3, sb3, sres3;
  logic [31:0]       pipe3_0, pipe3_1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_ptr = 0;

  arbitro_somador #(.WIDTH(32), .NUM_REQ(4), .LATENCY(1)) u1 (
    .clock(clk), .reset(rst), .req(req1),
    .entrada1(e1), .entrada2(e2),
    .grant(grant1), .done(done1), .resultado(res1),
    .soma_a(sa1), .soma_b(sb1), .soma_res(sres1)
  );

  arbitro_somador #(.WIDTH(32), .NUM_REQ(4), .LATENCY(3)) u3 (
    .clock(clk), .reset(rst), .req(req3),
    .entrada1(f1), .entrada2(f2),
    .grant(grant3), .done(done3), .resultado(res3),
    .soma_a(sa3), .soma_b(sb3), .soma_res(sres3)
  );

  // shared adders: LATENCY-1 register stages; resultado is the last
  assign sres1 = sa1 + sb1;
  always_ff @(posedge clk) begin
    pipe3_0 <= sa3 + sb3;
    pipe3_1 <= pipe3_0;
  end
  assign sres3 = pipe3_1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("onehot_grant1", 32'($onehot0(grant1)), 32'd1);
    chk("onehot_done1", 32'($onehot0(done1)), 32'd1);
    chk("onehot_grant3", 32'($onehot0(grant3)), 32'd1);
  end

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int off = 0; off < 4; off++)
      if (r[(p + off) % 4]) return (p + off) % 4;
    return -1;
  endfunction

  // called at a negedge; covers grant, done and exit edges
  task automatic do_op(input logic [3:0] r, input logic [3:0][31:0] a,
                       input logic [3:0][31:0] b, input int g,
                       input logic [31:0] exp_res);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    req1 = r;
    e1 = a;
    e2 = b;
    @(negedge clk);
    chk("grant", 32'(grant1), 32'(oh));
    chk("soma_a", sa1, a[g]);
    chk("soma_b", sb1, b[g]);
    chk("done_early", 32'(done1), 32'd0);
    @(negedge clk);
    chk("done", 32'(done1), 32'(oh));
    chk("resultado", res1, exp_res);
    chk("grant_clear", 32'(grant1), 32'd0);
    req1 = req1 & ~oh;
    @(negedge clk);
    chk("done_pulse", 32'(done1), 32'd0);
    m_ptr = (g + 1) % 4;
  endtask

  typedef struct {
    logic [3:0]       r;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    int               g;
    logic [31:0]      res;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [3:0][31:0] ra, rb;
    logic [3:0] rq;
    int g, prev_g, c0;

    for (int i = 0; i < 4; i++) begin
      tbl[i].a = '0;
      tbl[i].b = '0;
      for (int j = 0; j < 4; j++) begin
        tbl[i].a[j] = 32'(j);
        tbl[i].b[j] = 32'd10;
      end
      tbl[i].r   = 4'b1111 << i;
      tbl[i].g   = i;
      tbl[i].res = 32'(10 + i);
    end
    tbl[4] = '{4'b0010, '0, '0, 1, 32'd0};
    tbl[4].a[1] = 32'hFFFF_FFFF;
    tbl[4].b[1] = 32'd1;
    tbl[5] = '{4'b0100, '0, '0, 2, 32'd0};
    tbl[5].a[2] = 32'h8000_0000;
    tbl[5].b[2] = 32'h8000_0000;
    tbl[6] = '{4'b0001, '0, '0, 0, 32'd4};
    tbl[6].a[0] = 32'd1;
    tbl[6].b[0] = 32'd3;

    req1 = '0; e1 = '0; e2 = '0;
    req3 = '0; f1 = '0; f2 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_res", res1, 32'd0);
    chk("rst_sa", sa1, 32'd0);
    chk("rst_sb", sb1, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      do_op(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].res);
      if (i == 3) chk("throughput", 32'(cyc - c0), 32'd12);
    end

    // reset while busy drops the operation
    req1 = 4'b0010;
    e1 = '0; e2 = '0;
    e1[1] = 32'd5; e2[1] = 32'd6;
    @(negedge clk);
    chk("busy_grant", 32'(grant1), 32'b0010);
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant1), 32'd0);
    chk("arst_done", 32'(done1), 32'd0);
    chk("arst_res", res1, 32'd0);
    chk("arst_sa", sa1, 32'd0);
    chk("arst_sb", sb1, 32'd0);
    req1 = '0;
    @(negedge clk);
    rst = 1'b0;
    m_ptr = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", 32'(done1), 32'd0);
    end
    e1[1] = 32'd7; e2[1] = 32'd8;
    do_op(4'b0010, e1, e2, 1, 32'd15);

    // fairness: req 0 and 2 always pending
    prev_g = -1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        ra[j] = 32'(100 * i + j);
        rb[j] = 32'd1;
      end
      g = rr_pick(4'b0101, m_ptr);
      chk("fair_alt", 32'(g != prev_g), 32'd1);
      do_op(4'b0101, ra, rb, g, ra[g] + 32'd1);
      prev_g = g;
    end

    // randomized against the round-robin model
    for (int i = 0; i < 40; i++) begin
      rq = 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) begin
        ra[j] = $urandom;
        rb[j] = $urandom;
      end
      if (rq == 4'b0000) begin
        req1 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_grant", 32'(grant1), 32'd0);
        chk("idle_done", 32'(done1), 32'd0);
      end else begin
        g = rr_pick(rq, m_ptr);
        do_op(rq, ra, rb, g, ra[g] + rb[g]);
      end
    end
    req1 = '0;

    // latency 3, early drop and operand change after grant
    req3 = 4'b1000;
    f1[3] = 32'd100;
    f2[3] = 32'd23;
    @(negedge clk);
    chk("l3_grant", 32'(grant3), 32'b1000);
    chk("l3_sa", sa3, 32'd100);
    req3 = '0;
    f1[3] = 32'd999;
    @(negedge clk);
    chk("l3_busy1", 32'(done3), 32'd0);
    chk("l3_hold_grant", 32'(grant3), 32'b1000);
    chk("l3_frozen", sa3, 32'd100);
    @(negedge clk);
    chk("l3_busy2", 32'(done3), 32'd0);
    @(negedge clk);
    chk("l3_done", 32'(done3), 32'b1000);
    chk("l3_res", res3, 32'd123);
    chk("l3_grant_clear", 32'(grant3), 32'd0);
    @(negedge clk);
    chk("l3_done_pulse", 32'(done3), 32'd0);
    @(negedge clk);
    chk("l3_no_regrant", 32'(grant3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
